// File: rtl/adder_seq_ctrl.sv
// rtl/adder_seq_ctrl.sv - two-requester frame accumulator with round-robin grant
module adder_seq_ctrl #(
  parameter int N_OPS = 16,
  parameter int DW    = 4,
  parameter int SW    = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          valid0_i,
  input  logic [DW-1:0] data0_i,
  output logic          ready0_o,
  input  logic          valid1_i,
  input  logic [DW-1:0] data1_i,
  output logic          ready1_o,
  output logic          sum_valid_o,
  output logic [SW-1:0] sum_o,
  output logic          sum_src_o,
  input  logic          sum_ready_i
);

  localparam int CW = (N_OPS > 1) ? $clog2(N_OPS) : 1;

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t        state;
  state_t        state_nx;
  logic          grant;
  logic          ptr;
  logic          src;
  logic [SW-1:0] acc;
  logic [SW-1:0] sum;
  logic [CW-1:0] cnt;

  logic          g_valid;
  logic [DW-1:0] g_data;
  logic          hs;
  logic          last;
  logic [SW-1:0] acc_add;

  assign g_valid = grant ? valid1_i : valid0_i;
  assign g_data  = grant ? data1_i : data0_i;
  assign hs      = (state == ACC) && g_valid;
  assign last    = (cnt == CW'(N_OPS - 1));
  assign acc_add = acc + SW'(g_data);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      grant <= 1'b0;
      ptr   <= 1'b0;
      src   <= 1'b0;
      acc   <= '0;
      sum   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          // Contention goes to the pointer; a lone requester simply wins.
          if (valid0_i || valid1_i)
            grant <= (valid0_i && valid1_i) ? ptr : valid1_i;
        end
        ACC: begin
          if (hs) begin
            if (last) begin
              sum <= acc_add;
              src <= grant;
              acc <= '0;
              cnt <= '0;
            end else begin
              acc <= acc_add;
              cnt <= cnt + 1'b1;
            end
          end
        end
        OUT: begin
          if (sum_ready_i)
            ptr <= ~grant;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (valid0_i || valid1_i) state_nx = ACC;
      ACC:     if (hs && last) state_nx = OUT;
      OUT:     if (sum_ready_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ready0_o    = (state == ACC) && !grant;
    ready1_o    = (state == ACC) && grant;
    sum_valid_o = (state == OUT);
    sum_o       = sum;
    sum_src_o   = src;
  end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb/tb_adder_seq_ctrl.sv - directed self-checking bench for adder_seq_ctrl
module tb_adder_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid0;
  logic [3:0] data0;
  logic       ready0;
  logic       valid1;
  logic [3:0] data1;
  logic       ready1;
  logic       sum_valid;
  logic [7:0] sum;
  logic       sum_src;
  logic       sum_ready;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  adder_seq_ctrl #(.N_OPS(16), .DW(4), .SW(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .valid0_i    (valid0),
    .data0_i     (data0),
    .ready0_o    (ready0),
    .valid1_i    (valid1),
    .data1_i     (data1),
    .ready1_o    (ready1),
    .sum_valid_o (sum_valid),
    .sum_o       (sum),
    .sum_src_o   (sum_src),
    .sum_ready_i (sum_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one operand on a port and advance through its handshake edge.
  task automatic send_op(input int port, input logic [3:0] val);
    int budget;
    budget = 60;
    if (port == 0) begin valid0 = 1'b1; data0 = val; end
    else           begin valid1 = 1'b1; data1 = val; end
    while (((port == 0) ? ready0 : ready1) == 1'b0 && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) check("hs_timeout", 0, 1);
    else step();
  endtask

  task automatic wait_sum(input string tag);
    int budget;
    budget = 100;
    while (!sum_valid && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) check(tag, 0, 1);
  endtask

  initial begin
    int t_start;
    int bad;
    int f;
    logic [7:0] exp_sum [3];
    logic       exp_src [3];
    logic       other_rdy;

    rst = 1'b1; valid0 = 0; data0 = 0; valid1 = 0; data1 = 0; sum_ready = 0;
    step(); step();
    check("rst_ready0", ready0, 0);
    check("rst_ready1", ready1, 0);
    check("rst_sum_valid", sum_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_src", sum_src, 0);
    rst = 1'b0;
    step();

    // Single frame on port 0: 1..15,0 back-to-back
    sum_ready = 1'b1;
    check("t1_idle_ready", ready0, 0);
    t_start = cyc;
    for (int i = 0; i < 16; i++) send_op(0, 4'((i + 1) % 16));
    valid0 = 1'b0;
    check("t1_latency", cyc - t_start, 17);
    check("t1_valid", sum_valid, 1);
    check("t1_sum", sum, 120);
    check("t1_src", sum_src, 0);
    step();
    check("t1_accept", sum_valid, 0);
    check("t1_frame_len", cyc - t_start, 18);

    // Maximum operands on port 1
    for (int i = 0; i < 16; i++) send_op(1, 4'hF);
    valid1 = 1'b0;
    check("t2_valid", sum_valid, 1);
    check("t2_sum", sum, 240);
    check("t2_src", sum_src, 1);
    step();

    // Contention from reset: alternating grant, other ready stays low
    rst = 1'b1; step(); rst = 1'b0;
    exp_sum[0] = 16; exp_sum[1] = 32; exp_sum[2] = 16;
    exp_src[0] = 0;  exp_src[1] = 1;  exp_src[2] = 0;
    valid0 = 1'b1; data0 = 4'd1; valid1 = 1'b1; data1 = 4'd2;
    bad = 0; f = 0;
    for (int c = 0; c < 200 && f < 3; c++) begin
      other_rdy = exp_src[f] ? ready0 : ready1;
      if (other_rdy) bad++;
      if (sum_valid) begin
        check($sformatf("t3_sum%0d", f), sum, exp_sum[f]);
        check($sformatf("t3_src%0d", f), sum_src, exp_src[f]);
        f++;
      end
      if (f < 3) step();
    end
    check("t3_frames", f, 3);
    check("t3_other_ready", bad, 0);
    valid0 = 1'b0; valid1 = 1'b0;
    step();
    check("t3_idle", sum_valid, 0);

    // Stalls: gaps on port 0, consumer holds off 5 cycles
    sum_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send_op(0, (i % 2) ? 4'd9 : 4'd5);
      valid0 = 1'b0;
      if (i < 15) step();
    end
    for (int c = 0; c < 5; c++) begin
      check($sformatf("t4_valid_c%0d", c), sum_valid, 1);
      check($sformatf("t4_sum_c%0d", c), sum, 112);
      check($sformatf("t4_src_c%0d", c), sum_src, 0);
      check($sformatf("t4_rdy_c%0d", c), {ready1, ready0}, 0);
      step();
    end
    sum_ready = 1'b1;
    step();
    check("t4_accept", sum_valid, 0);

    // Reset mid-frame discards partial sum and clears the pointer
    for (int i = 0; i < 7; i++) send_op(0, 4'd7);
    valid0 = 1'b0;
    rst = 1'b1;
    step();
    check("t5_ready0", ready0, 0);
    check("t5_ready1", ready1, 0);
    check("t5_valid", sum_valid, 0);
    check("t5_sum", sum, 0);
    check("t5_src", sum_src, 0);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (sum_valid) bad++;
    end
    check("t5_no_pulse", bad, 0);
    valid0 = 1'b1; data0 = 4'd3; valid1 = 1'b1; data1 = 4'd1;
    wait_sum("t5_timeout");
    valid0 = 1'b0; valid1 = 1'b0;
    check("t5_sum_fresh", sum, 48);
    check("t5_src_fresh", sum_src, 0);
    step();
    check("t5_accept", sum_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/adder_seq_ctrl.md
ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

Interface
REQ-001 Parameter N_OPS, default 16, meaning operands per frame; legal range 2..256.
REQ-002 Parameter DW, default 4, meaning operand width in bits.
REQ-003 Parameter SW, default 8, meaning sum width; SW SHALL be >= DW + clog2(N_OPS).
REQ-004 clk_i  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 valid0_i  input  1  requester 0 operand valid.
REQ-007 data0_i  input  DW  requester 0 operand, unsigned.
REQ-008 ready0_o  output  1  requester 0 operand accepted when high with valid0_i.
REQ-009 valid1_i  input  1  requester 1 operand valid.
REQ-010 data1_i  input  DW  requester 1 operand, unsigned.
REQ-011 ready1_o  output  1  requester 1 operand accepted when high with valid1_i.
REQ-012 sum_valid_o  output  1  frame result available.
REQ-013 sum_o  output  SW  unsigned sum of the N_OPS operands of one frame.
REQ-014 sum_src_o  output  1  index of the requester that produced sum_o.
REQ-015 sum_ready_i  input  1  consumer accepts the result when high with sum_valid_o.

Function
REQ-016 The block SHALL share one accumulator between two requesters, one frame (N_OPS operands) at a time, with a registered FSM of states IDLE, ACC, OUT.
REQ-017 IDLE: ready0_o = ready1_o = 0, sum_valid_o = 0; if any valid_i is high, grant SHALL be registered and state SHALL go to ACC next cycle; else stay IDLE.
REQ-018 Arbitration: single requester valid -> that requester granted; both valid -> requester equal to the round-robin pointer granted.
REQ-019 Round-robin pointer SHALL reset to 0 and SHALL be set to the non-granted index when a result is accepted in OUT.
REQ-020 Grant SHALL be held for the whole frame; the non-granted ready_o SHALL stay 0 until the frame result is accepted.
REQ-021 ACC: ready of the granted port SHALL be 1, other ready 0; on handshake (valid & ready) accumulator += zero-extended data and operand counter increments.
REQ-022 ACC with granted valid low: accumulator and counter hold; no timeout, no abort.
REQ-023 On the handshake of operand N_OPS-1 (counter == N_OPS-1), sum_o SHALL be loaded with accumulator + data, sum_src_o with the grant, and state SHALL go to OUT; accumulator and counter SHALL clear.
REQ-024 Accumulation SHALL be exact (no overflow) given REQ-003; all arithmetic unsigned.
REQ-025 OUT: sum_valid_o = 1, both ready_o = 0; sum_o and sum_src_o SHALL hold stable until sum_ready_i; on sum_valid_o & sum_ready_i state SHALL return to IDLE.
REQ-026 Latency: with continuous valid and sum_ready_i high, a frame SHALL occupy 1 (IDLE) + N_OPS (ACC) + 1 (OUT) cycles; result first visible the cycle after the last operand handshake.
REQ-027 ready_o SHALL depend only on registered state, not combinationally on valid_i or sum_ready_i.
REQ-028 A requester that deasserts valid mid-frame SHALL keep its grant; the other requester SHALL wait.

Reset
REQ-029 While rst_i is high at a clock edge: state -> IDLE, accumulator, counter, grant, pointer -> 0; sum_valid_o = 0, sum_o = 0, sum_src_o = 0, ready0_o = ready1_o = 0.
REQ-030 Reset asserted mid-frame or in OUT SHALL discard the partial/pending result; no sum_valid_o pulse after reset until a new complete frame.

Verification
REQ-031 Single frame: port0 sends 16 operands 1..15,0 back-to-back, sum_ready_i=1 -> sum_valid_o one cycle after 16th handshake, sum_o=120, sum_src_o=0; frame takes 18 cycles.
REQ-032 Max value: port1 sends 16 x 4'hF -> sum_o=240 (8'hF0), sum_src_o=1, no overflow.
REQ-033 Contention: both valid continuously after reset, port0 all 1s, port1 all 2s -> results alternate 16 (src 0), 32 (src 1), 16 (src 0); other ready stays 0 throughout each frame.
REQ-034 Stalls: port0 valid toggled every other cycle, sum_ready_i held low 5 cycles in OUT -> counter holds during gaps, sum_o and sum_src_o stable for all 5 cycles, correct sum on acceptance.
REQ-035 Reset mid-frame: rst_i high after 7 operands of port0 -> next cycle all outputs 0, state IDLE; fresh 16-operand frame of 3s -> sum_o=48, pointer=0 after reset.
